// File: rtl/song_session_ctrl.sv
// Game-flow sequencer for the score loader: idle, optional count-in, play, result hold.
// The count-in phase is present only when SONG_COUNTIN_EN is defined.
module song_session_ctrl #(
    parameter int COUNT_IN_BEATS = 4,
    parameter int RESULT_HOLD    = 27_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  song_select,
    input  logic [25:0] tempo,
    input  logic        song_done,
    output logic [1:0]  song_id,
    output logic        loader_reset,
    output logic [1:0]  state,
    output logic [2:0]  count_in,
    output logic        beat,
    output logic        playing,
    output logic [7:0]  plays
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNTIN = 2'd1,
        ST_PLAY    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [2:0]  CIN_INIT  = 3'(COUNT_IN_BEATS);
    localparam logic [25:0] HOLD_LAST = 26'(RESULT_HOLD - 1);

    state_t      r_state;
    logic [1:0]  r_song_id;
    logic        r_loader_reset;
    logic [2:0]  r_count_in;
    logic        r_beat;
    logic        r_playing;
    logic [7:0]  r_plays;
    logic [25:0] r_hold_cnt;
    logic        w_start_ok;

    assign w_start_ok = start & ~abort;

`ifdef SONG_COUNTIN_EN
    logic [25:0] r_beat_cnt;
    logic [25:0] w_beat_last;
    logic        w_beat_wrap;

    // Last beat-counter value of a beat period; zero tempo means a one-cycle period.
    always_comb begin
        if (tempo == 26'd0) begin
            w_beat_last = 26'd0;
        end else begin
            w_beat_last = tempo - 26'd1;
        end
    end

    assign w_beat_wrap = (r_beat_cnt == w_beat_last);
`else
    logic w_unused_tempo;
    assign w_unused_tempo = ^tempo;
`endif

    // Session state machine with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_song_id      <= 2'd0;
            r_loader_reset <= 1'b1;
            r_count_in     <= 3'd0;
            r_beat         <= 1'b0;
            r_playing      <= 1'b0;
            r_plays        <= 8'd0;
            r_hold_cnt     <= 26'd0;
`ifdef SONG_COUNTIN_EN
            r_beat_cnt     <= 26'd0;
`endif
        end else begin
            r_beat <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_song_id <= song_select;
`ifdef SONG_COUNTIN_EN
                        r_beat_cnt <= 26'd0;
                        r_count_in <= CIN_INIT;
                        r_state    <= ST_COUNTIN;
`else
                        r_state        <= ST_PLAY;
                        r_loader_reset <= 1'b0;
                        r_playing      <= 1'b1;
`endif
                    end
                end
                ST_COUNTIN: begin
`ifdef SONG_COUNTIN_EN
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_beat_wrap) begin
                        r_beat_cnt <= 26'd0;
                        r_count_in <= r_count_in - 3'd1;
                        r_beat     <= 1'b1;
                        // The final beat and the release of the loader share one edge.
                        if (r_count_in == 3'd1) begin
                            r_state        <= ST_PLAY;
                            r_loader_reset <= 1'b0;
                            r_playing      <= 1'b1;
                        end
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 26'd1;
                    end
`else
                    r_state        <= ST_IDLE;
                    r_loader_reset <= 1'b1;
                    r_playing      <= 1'b0;
`endif
                end
                ST_PLAY: begin
                    if (abort) begin
                        r_state        <= ST_IDLE;
                        r_loader_reset <= 1'b1;
                        r_playing      <= 1'b0;
                    end else if (song_done) begin
                        r_state    <= ST_DONE;
                        r_playing  <= 1'b0;
                        r_hold_cnt <= 26'd0;
                        if (r_plays != 8'd255) begin
                            r_plays <= r_plays + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort || (r_hold_cnt == HOLD_LAST)) begin
                        r_state        <= ST_IDLE;
                        r_loader_reset <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 26'd1;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_loader_reset <= 1'b1;
                    r_playing      <= 1'b0;
                end
            endcase
        end
    end

    assign song_id      = r_song_id;
    assign loader_reset = r_loader_reset;
    assign state        = r_state;
    assign count_in     = r_count_in;
    assign beat         = r_beat;
    assign playing      = r_playing;
    assign plays        = r_plays;

endmodule

// File: tb/tb_song_session_ctrl.sv
// Self-checking bench for song_session_ctrl: directed scenarios plus random traffic
// compared against an elapsed-time reference model. Works with or without SONG_COUNTIN_EN.
module tb_song_session_ctrl;
    localparam int BEATS = 4;
    localparam int HOLD  = 8;

    logic        clk = 1'b0;
    logic        reset, start, abort, song_done;
    logic [1:0]  song_select;
    logic [25:0] tempo;
    logic [1:0]  song_id, state;
    logic        loader_reset, beat, playing;
    logic [2:0]  count_in;
    logic [7:0]  plays;

    int n_checks = 0;
    int n_errors = 0;
    int plays_exp = 0;

    always #5 clk = ~clk;

    song_session_ctrl #(.COUNT_IN_BEATS(BEATS), .RESULT_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .song_select(song_select), .tempo(tempo), .song_done(song_done),
        .song_id(song_id), .loader_reset(loader_reset), .state(state),
        .count_in(count_in), .beat(beat), .playing(playing), .plays(plays)
    );

    // Reference model: phases timed by cycles elapsed since phase entry.
    int cyc = 0;
    int m_state = 0, m_song = 0, m_cin = 0, m_beat = 0, m_plays = 0, m_phase = 0;
    int m_e, m_t;
    assign m_e = cyc + 1 - m_phase;
    assign m_t = (tempo == 26'd0) ? 1 : int'(tempo);

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_beat <= 0;
        if (reset) begin
            m_state <= 0; m_song <= 0; m_cin <= 0; m_plays <= 0; m_phase <= 0;
        end else if (m_state == 0) begin
            if (start && !abort) begin
                m_song  <= int'(song_select);
                m_phase <= cyc + 1;
`ifdef SONG_COUNTIN_EN
                m_state <= 1;
                m_cin   <= BEATS;
`else
                m_state <= 2;
`endif
            end
        end else if (abort) begin
            m_state <= 0;
        end else if (m_state == 1) begin
            if (m_e % m_t == 0) begin
                m_beat <= 1;
                m_cin  <= BEATS - m_e / m_t;
                if (m_e / m_t == BEATS) m_state <= 2;
            end
        end else if (m_state == 2) begin
            if (song_done) begin
                m_state <= 3;
                m_plays <= (m_plays == 255) ? 255 : m_plays + 1;
                m_phase <= cyc + 1;
            end
        end else if (m_e == HOLD) begin
            m_state <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; abort = 1'b0; song_done = 1'b0; reset = 1'b0;
    endtask

    // Starts a session and waits the nominal time to reach PLAY.
    task automatic go_play(input logic [1:0] sel, input logic [25:0] tmp);
        int per;
        per = (tmp == 26'd0) ? 1 : int'(tmp);
        tempo = tmp; song_select = sel; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SONG_COUNTIN_EN
        repeat (BEATS * per) tick();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; song_done = 1'b0;
        song_select = 2'd0; tempo = 26'd4;
        tick(); tick();
        reset = 1'b0;
        plays_exp = 0;
        n_checks++;
        if ({state, loader_reset, song_id, count_in, beat, playing, plays} !== {2'd0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_values got st=%0d lr=%0d id=%0d cin=%0d beat=%0d pl=%0d plays=%0d exp 0/1/0/0/0/0/0",
                     state, loader_reset, song_id, count_in, beat, playing, plays);
        end
        repeat (5) tick();
    endtask

    task automatic test_countin();
        tempo = 26'd4; song_select = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SONG_COUNTIN_EN
        n_checks++;
        if ({state, song_id, count_in, loader_reset} !== {2'd1, 2'd2, 3'd4, 1'b1}) begin
            n_errors++;
            $display("FAIL countin_entry got st=%0d id=%0d cin=%0d lr=%0d exp 1/2/4/1", state, song_id, count_in, loader_reset);
        end
        for (int i = 2; i <= 17; i++) begin
            logic       e_beat;
            logic [2:0] e_cin;
            logic [1:0] e_st;
            tick();
            e_beat = ((i - 1) % 4 == 0);
            e_cin  = 3'(4 - (i - 1) / 4);
            e_st   = (i == 17) ? 2'd2 : 2'd1;
            n_checks++;
            if ({beat, count_in, state, loader_reset} !== {e_beat, e_cin, e_st, (i != 17)}) begin
                n_errors++;
                $display("FAIL countin_step i=%0d got beat=%0d cin=%0d st=%0d lr=%0d exp beat=%0d cin=%0d st=%0d lr=%0d",
                         i, beat, count_in, state, loader_reset, e_beat, e_cin, e_st, (i != 17));
            end
        end
`else
        n_checks++;
        if ({state, song_id, loader_reset, playing} !== {2'd2, 2'd2, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL direct_play got st=%0d id=%0d lr=%0d pl=%0d exp 2/2/0/1", state, song_id, loader_reset, playing);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({beat, count_in} !== 4'd0) begin
                n_errors++;
                $display("FAIL no_beat got beat=%0d cin=%0d exp 0/0", beat, count_in);
            end
        end
`endif
    endtask

    task automatic test_song_end();
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        plays_exp++;
        n_checks++;
        if ({state, loader_reset, plays} !== {2'd3, 1'b0, 8'(plays_exp)}) begin
            n_errors++;
            $display("FAIL done_entry got st=%0d lr=%0d plays=%0d exp 3/0/%0d", state, loader_reset, plays, plays_exp);
        end
        for (int j = 2; j <= 9; j++) begin
            tick();
            n_checks++;
            if ({state, loader_reset} !== {((j == 9) ? 2'd0 : 2'd3), (j == 9)}) begin
                n_errors++;
                $display("FAIL done_hold j=%0d got st=%0d lr=%0d exp st=%0d lr=%0d",
                         j, state, loader_reset, (j == 9) ? 0 : 3, (j == 9));
            end
        end
    endtask

    task automatic test_abort();
        tempo = 26'd4; song_select = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SONG_COUNTIN_EN
        repeat (8) tick();
        n_checks++;
        if (count_in !== 3'd2) begin
            n_errors++;
            $display("FAIL abort_pre got cin=%0d exp 2", count_in);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({state, count_in, plays, loader_reset} !== {2'd0, 3'd2, 8'(plays_exp), 1'b1}) begin
            n_errors++;
            $display("FAIL abort_countin got st=%0d cin=%0d plays=%0d lr=%0d exp 0/2/%0d/1", state, count_in, plays, loader_reset, plays_exp);
        end
`else
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({state, plays, loader_reset, playing} !== {2'd0, 8'(plays_exp), 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL abort_play got st=%0d plays=%0d lr=%0d pl=%0d exp 0/%0d/1/0", state, plays, loader_reset, playing, plays_exp);
        end
`endif
        start = 1'b1; abort = 1'b1; song_select = 2'd3;
        tick();
        quiet();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({state, loader_reset, song_id} !== {2'd0, 1'b1, 2'd1}) begin
                n_errors++;
                $display("FAIL start_abort k=%0d got st=%0d lr=%0d id=%0d exp 0/1/1", k, state, loader_reset, song_id);
            end
            tick();
        end
    endtask

    task automatic test_ignored();
        tempo = 26'd0; song_select = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SONG_COUNTIN_EN
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        n_checks++;
        if ({state, plays} !== {2'd1, 8'(plays_exp)}) begin
            n_errors++;
            $display("FAIL done_in_countin got st=%0d plays=%0d exp 1/%0d", state, plays, plays_exp);
        end
        repeat (3) tick();
`endif
        song_select = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({state, song_id} !== {2'd2, 2'd3}) begin
            n_errors++;
            $display("FAIL start_in_play got st=%0d id=%0d exp 2/3", state, song_id);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_tempo0();
`ifdef SONG_COUNTIN_EN
        tempo = 26'd0; song_select = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({state, beat, count_in} !== {2'd1, 1'b0, 3'd4}) begin
            n_errors++;
            $display("FAIL tempo0_entry got st=%0d beat=%0d cin=%0d exp 1/0/4", state, beat, count_in);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if ({beat, count_in, state} !== {1'b1, 3'(4 - k), ((k == 4) ? 2'd2 : 2'd1)}) begin
                n_errors++;
                $display("FAIL tempo0_beat k=%0d got beat=%0d cin=%0d st=%0d exp 1/%0d/%0d",
                         k, beat, count_in, state, 4 - k, (k == 4) ? 2 : 1);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
    endtask

    task automatic test_saturate();
        for (int s = 1; s <= 256; s++) begin
            go_play(2'd0, 26'd0);
            song_done = 1'b1;
            tick();
            song_done = 1'b0;
            abort = 1'b1;
            tick();
            abort = 1'b0;
            if (plays_exp < 255) plays_exp++;
            if (s == 255 || s == 256) begin
                n_checks++;
                if ({plays, state} !== {8'd255, 2'd0}) begin
                    n_errors++;
                    $display("FAIL plays_sat s=%0d got plays=%0d st=%0d exp 255/0", s, plays, state);
                end
            end
        end
    endtask

    task automatic test_reset_in_done();
        go_play(2'd2, 26'd2);
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        tick();
        n_checks++;
        if (state !== 2'd3) begin
            n_errors++;
            $display("FAIL reach_done got st=%0d exp 3", state);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        plays_exp = 0;
        n_checks++;
        if ({state, plays, loader_reset, song_id, playing} !== {2'd0, 8'd0, 1'b1, 2'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_in_done got st=%0d plays=%0d lr=%0d id=%0d pl=%0d exp 0/0/1/0/0",
                     state, plays, loader_reset, song_id, playing);
        end
    endtask

    task automatic test_random();
        logic [17:0] got, exp;
        for (int n = 0; n < 3000; n++) begin
            start       = ($urandom % 8) == 0;
            abort       = ($urandom % 32) == 0;
            song_done   = ($urandom % 16) == 0;
            reset       = ($urandom % 500) == 0;
            song_select = 2'($urandom % 4);
            if (m_state == 0) tempo = 26'($urandom % 6);
            tick();
            got = {state, song_id, loader_reset, count_in, beat, playing, plays};
            exp = {2'(m_state), 2'(m_song), (m_state <= 1), 3'(m_cin), 1'(m_beat), (m_state == 2), 8'(m_plays)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_countin();
        test_song_end();
        test_abort();
        test_ignored();
        test_tempo0();
        test_saturate();
        test_reset_in_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
